mem_arbiter4: RTL and testbench
===============================

# mem_arbiter4

Four-requester round-robin arbiter sharing the single data-memory port between four masters (LSU, instruction prefetch, debug/loader, spare). Grants one requester at a time and drives the 2-bit select of the 4:1 address/write-data/write-enable muxes in front of the memory. Sequences a valid/ready transaction on the memory side and returns a one-cycle completion strobe to the winner. Sits between the requesters and the data-memory port in the top level.

## Interface
- DATA_WIDTH, 32, read-data width, broadcast to requesters
- NUM_REQ, 4, requester count; fixed at 4, sized to the 2-bit select
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  [3:0]  per-requester request; held high until its done strobe
- lock  input  [3:0]  per-requester bus lock, used only under ARB_LOCK_EN
- gnt  output  [3:0]  one-hot grant, registered
- sel  output  [1:0]  encoded grant index to the 4:1 muxes, registered
- mem_valid  output  1  memory transaction request
- mem_ready  input  1  memory accepts/completes the transaction this cycle
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ready
- done  output  [3:0]  one-hot completion, combinational: gnt & {4{mem_ready & mem_valid}}
- rdata  output  DATA_WIDTH  mem_rdata passed through; meaningful only with done

## Operation
- FSM states: IDLE, BUSY.
- IDLE: mem_valid=0, gnt=0. If any req bit is set, pick the winner by round robin. Search order is last+1, last+2, last+3, last (mod 4). Register gnt=onehot(winner), sel=winner, go to BUSY.
- BUSY: mem_valid=1, gnt and sel held stable. On mem_ready: done[sel]=1 for that cycle, last<=sel, next state IDLE.
- Minimum one IDLE cycle between transactions; max throughput is one transfer per 2 cycles.
- Requester obligation: keep req high until done is sampled. Deasserting req while BUSY is illegal and is ignored; the transaction completes.
- req bits of non-granted requesters may change freely. Only the IDLE-cycle value matters.
- Simultaneous requests: highest-priority bit in the rotated order wins. The loser keeps req and is served within at most 3 further grants (starvation-free).
- mem_ready while IDLE is ignored: no done, no state change.

## Timing
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, mem_valid=0, done=0, last=3 (requester 0 first after reset).
- Latency: req rises in cycle N (IDLE) → gnt/sel/mem_valid high in cycle N+1.
- mem_ready in cycle N+1 → done in N+1 → IDLE in N+2 → next grant in N+3.
- sel is valid and stable for the whole BUSY interval. The muxes are combinational, so address/wdata reach memory in the same cycle as mem_valid.
- Reset asserted mid-BUSY: outputs clear immediately (async). The transaction is dropped with no done. last returns to 3.

## Configuration
- ARB_LOCK_EN defined: on mem_ready in BUSY, if lock[sel] & req[sel] is high in that cycle, stay in BUSY with the same grant. There is no IDLE gap, done pulses per transfer, and last is not updated until the lock drops.
- ARB_LOCK_EN undefined: the lock port exists but is ignored, and every transfer returns to IDLE.

## Structure
- Package mem_arb_pkg: typedef arb_state_t {IDLE, BUSY}; NUM_REQ=4; SEL_W=2.
- One sub-module, rr_pick4: combinational rotated priority picker. Inputs are req[3:0] and last[1:0]. Outputs are winner[1:0] and any_req.
- The arbiter instantiates rr_pick4 plus the FSM and last/gnt/sel registers. The 4:1 datapath muxes stay outside this block and are driven by sel.

## Test plan
- Reset then req=4'b0001 → gnt=0001, sel=0, mem_valid=1 next cycle; mem_ready → done=0001, IDLE.
- req=4'b1111 held, mem_ready always 1 → grant order 0,1,2,3,0, one grant every 2 cycles.
- last=1, req=4'b1001 → grant 3, then grant 0.
- mem_ready held 0 for 5 cycles in BUSY while req changes on other bits → gnt/sel stable, no done until mem_ready.
- rst_n low mid-BUSY → gnt=0, mem_valid=0 immediately; after release, req=4'b1100 → grant 2.
- ARB_LOCK_EN, lock[1]=1, req=4'b0011 → three back-to-back transfers to requester 1 with no IDLE gap; lock drops → next grant 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-requester memory arbiter.
// ARB_LOCK_EN (optional) enables back-to-back locked transfers.
package mem_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mem_arbiter4_rr_pick4.sv
// Rotated-priority picker: searches last+1, last+2, last+3, last.
// Pure combinational; no state.
module rr_pick4
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic [SEL_W-1:0] idx;

  // Walk from lowest priority to highest so the nearest hit wins.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/mem_arbiter4.sv
// Round-robin arbiter for the shared data-memory port.
// Define ARB_LOCK_EN to let a locked winner keep the port across transfers.
module mem_arbiter4
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    lock,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [SEL_W-1:0]      sel,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [NUM_REQ-1:0]    done,
  output logic [DATA_WIDTH-1:0] rdata
);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [SEL_W-1:0]   last_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [SEL_W-1:0]   winner;
  logic               any_req;
  logic               xfer;
  logic               hold;
  logic               grant;
  logic               release_bus;

  rr_pick4 u_pick (
    .req     (req),
    .last    (last_q),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef ARB_LOCK_EN
  assign hold = lock[sel_q] & req[sel_q];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold        = 1'b0;
`endif

  assign xfer        = mem_valid & mem_ready;
  assign grant       = (state_q == IDLE) & any_req;
  assign release_bus = xfer & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req)     state_d = BUSY;
      BUSY: if (release_bus) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = (state_q == BUSY);
  end

  // last only moves when the bus is actually given back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      sel_q  <= '0;
      last_q <= SEL_W'(NUM_REQ - 1);
    end else if (grant) begin
      gnt_q  <= onehot(winner);
      sel_q  <= winner;
    end else if (release_bus) begin
      gnt_q  <= '0;
      last_q <= sel_q;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign done  = gnt_q & {NUM_REQ{xfer}};
  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter4.sv
// Randomized and directed bench for mem_arbiter4.
// Reference model works on integer requester indices.
module tb_mem_arbiter4;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [3:0]    lock;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    done;
  logic [DW-1:0] rdata;

  int checks;
  int errors;

  int m_cur;
  int m_last;
  int m_sel;
  bit m_lock_en;

  mem_arbiter4 #(.DATA_WIDTH(DW), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .sel       (sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .done      (done),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    m_cur  = -1;
    m_last = 3;
    m_sel  = 0;
  endfunction

  function automatic logic [3:0] m_gnt();
    logic [3:0] v;
    v = '0;
    if (m_cur >= 0) v[m_cur] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] m_done();
    logic [3:0] v;
    v = '0;
    if (m_cur >= 0 && mem_ready) v[m_cur] = 1'b1;
    return v;
  endfunction

  // Advance the model across one rising edge using current inputs.
  function automatic void m_step();
    int c;
    if (m_cur < 0) begin
      for (int k = 4; k >= 1; k--) begin
        c = (m_last + k) % 4;
        if (req[c]) m_cur = c;
      end
      if (m_cur >= 0) m_sel = m_cur;
    end else if (mem_ready) begin
      if (!(m_lock_en && lock[m_cur] && req[m_cur])) begin
        m_last = m_cur;
        m_cur  = -1;
      end
    end
  endfunction

  task automatic drive(input logic [3:0] r, input logic rdy,
                       input logic [3:0] lk);
    @(negedge clk);
    req       = r;
    mem_ready = rdy;
    lock      = lk;
    mem_rdata = $urandom;
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = '0;
    lock      = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    lock      = '0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({gnt, sel, mem_valid, done} !== 11'b0) begin
      errors++;
      $display("FAIL reset: gnt=%b sel=%0d valid=%b done=%b want all 0",
               gnt, sel, mem_valid, done);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    drive(4'b0001, 1'b1, 4'b0);
    checks++;
    if (gnt !== 4'b0 || mem_valid !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL single_idle: gnt=%b valid=%b done=%b want 0/0/0",
               gnt, mem_valid, done);
    end
    m_step();
    drive(4'b0001, 1'b1, 4'b0);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || mem_valid !== 1'b1 ||
        done !== 4'b0001) begin
      errors++;
      $display("FAIL single_busy: gnt=%b sel=%0d valid=%b done=%b want 0001/0/1/0001",
               gnt, sel, mem_valid, done);
    end
    checks++;
    if (rdata !== mem_rdata) begin
      errors++;
      $display("FAIL rdata: got %h want %h", rdata, mem_rdata);
    end
    m_step();
    drive(4'b0000, 1'b0, 4'b0);
    checks++;
    if (gnt !== 4'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_back_idle: gnt=%b valid=%b want 0/0",
               gnt, mem_valid);
    end
    m_step();
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(4'b1111, 1'b1, 4'b0);
      checks++;
      if (gnt !== m_gnt() || mem_valid !== (m_cur >= 0) ||
          done !== m_done()) begin
        errors++;
        $display("FAIL rr_cycle%0d: gnt=%b valid=%b done=%b want %b/%b/%b",
                 cyc, gnt, mem_valid, done, m_gnt(), m_cur >= 0, m_done());
      end
      if (mem_valid) order.push_back(int'(sel));
      m_step();
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d want %0d",
                   i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_last_priority();
    apply_reset();
    drive(4'b0010, 1'b0, 4'b0); m_step();
    drive(4'b0010, 1'b1, 4'b0); m_step();
    drive(4'b1001, 1'b1, 4'b0); m_step();
    drive(4'b1001, 1'b1, 4'b0);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      errors++;
      $display("FAIL last1_first: gnt=%b sel=%0d want 1000/3", gnt, sel);
    end
    m_step();
    drive(4'b0001, 1'b1, 4'b0); m_step();
    drive(4'b0001, 1'b1, 4'b0);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || done !== 4'b0001) begin
      errors++;
      $display("FAIL last1_second: gnt=%b sel=%0d done=%b want 0001/0/0001",
               gnt, sel, done);
    end
    m_step();
  endtask

  task automatic test_stall();
    logic [3:0] r;
    apply_reset();
    drive(4'b0100, 1'b0, 4'b0); m_step();
    for (int i = 0; i < 5; i++) begin
      r = 4'($urandom) | 4'b0100;
      drive(r, 1'b0, 4'b0);
      checks++;
      if (gnt !== 4'b0100 || sel !== 2'd2 || mem_valid !== 1'b1 ||
          done !== 4'b0) begin
        errors++;
        $display("FAIL stall%0d: gnt=%b sel=%0d valid=%b done=%b want 0100/2/1/0000",
                 i, gnt, sel, mem_valid, done);
      end
      m_step();
    end
    drive(4'b1111, 1'b1, 4'b0);
    checks++;
    if (done !== 4'b0100) begin
      errors++;
      $display("FAIL stall_done: got %b want 0100", done);
    end
    m_step();
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(4'b0010, 1'b0, 4'b0); m_step();
    drive(4'b0010, 1'b0, 4'b0);
    checks++;
    if (mem_valid !== 1'b1 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL arst_pre: valid=%b gnt=%b want 1/0010", mem_valid, gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || mem_valid !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL arst_clear: gnt=%b valid=%b done=%b want 0/0/0",
               gnt, mem_valid, done);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    drive(4'b1100, 1'b0, 4'b0); m_step();
    drive(4'b1100, 1'b1, 4'b0);
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      errors++;
      $display("FAIL arst_after: gnt=%b sel=%0d want 0100/2", gnt, sel);
    end
    m_step();
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] lk;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r  = 4'($urandom);
      lk = 4'($urandom_range(0, 15)) & 4'($urandom);
      if (m_cur >= 0) r[m_cur] = 1'b1;
      drive(r, 1'($urandom_range(0, 2) != 0), lk);
      checks++;
      if (gnt !== m_gnt() || sel !== 2'(m_sel) ||
          mem_valid !== (m_cur >= 0) || done !== m_done()) begin
        errors++;
        $display("FAIL rand%0d: gnt=%b sel=%0d valid=%b done=%b want %b/%0d/%b/%b",
                 cyc, gnt, sel, mem_valid, done,
                 m_gnt(), m_sel, m_cur >= 0, m_done());
      end
      m_step();
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    drive(4'b0001, 1'b0, 4'b0); m_step();
    drive(4'b0001, 1'b1, 4'b0); m_step();
    drive(4'b0011, 1'b1, 4'b0010); m_step();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 1'b1, (i < 2) ? 4'b0010 : 4'b0000);
      checks++;
      if (gnt !== 4'b0010 || mem_valid !== 1'b1 || done !== 4'b0010) begin
        errors++;
        $display("FAIL lock_xfer%0d: gnt=%b valid=%b done=%b want 0010/1/0010",
                 i, gnt, mem_valid, done);
      end
      m_step();
    end
    drive(4'b0001, 1'b0, 4'b0); m_step();
    drive(4'b0001, 1'b1, 4'b0);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL lock_after: gnt=%b want 0001", gnt);
    end
    m_step();
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    mem_rdata = '0;
`ifdef ARB_LOCK_EN
    m_lock_en = 1'b1;
`else
    m_lock_en = 1'b0;
`endif
    m_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_last_priority();
    test_stall();
    test_async_reset();
    test_random();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
